// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands one nibble per clock through a shared 4-bit ripple_carry
module ripple_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c
);
  logic [4:0] k;
  genvar i;
  assign k[0] = ci;
  for (i = 0; i < 4; i++) begin : g
    assign s[i]   = a[i] ^ b[i] ^ k[i];
    assign k[i+1] = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i]));
  end
  assign c = k[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic {IDLE, ADD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nx;
  logic [WIDTH+3:0] cat;
  logic [CW-1:0] cnt;
  logic [3:0] rs;
  logic cy, rc, msba, msbb, last;
  ripple_carry u_rc (.a(a_sh[3:0]), .b(b_sh[3:0]), .ci(cy), .s(rs), .c(rc));
  // the fresh slice sum enters at the top, so after the last slice S_sh holds the full result in order
  assign cat  = {rs, s_sh};
  assign s_nx = cat[WIDTH+3:4];
  assign last = cnt == CW'(NIBBLES - 1);
  assign busy = state == ADD;
  always_comb begin
    state_nx = state == IDLE ? (start ? ADD : IDLE) : (last ? IDLE : ADD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      msba  <= 1'b0;
      msbb  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == ADD && last;
      if (state == IDLE && start) begin
        a_sh <= in1;
        b_sh <= in2;
        cy   <= cin;
        msba <= in1[WIDTH-1];
        msbb <= in2[WIDTH-1];
        cnt  <= '0;
      end else if (state == ADD) begin
        a_sh <= a_sh >> 4;
        b_sh <= b_sh >> 4;
        s_sh <= s_nx;
        cy   <= rc;
        cnt  <= cnt + CW'(1);
        if (last) begin
          s <= s_nx;
          c <= rc;
          v <= (msba == msbb) && (s_nx[WIDTH-1] != msba);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table vectors plus hand sequences, checked through a done-driven scoreboard
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic busy, done, c, v;
  logic [W-1:0] s;
  int checks = 0, failures = 0;
  typedef struct {logic [W-1:0] a, b; logic ci; logic [W-1:0] s; logic c, v;} vec_t;
  vec_t tbl[7];
  vec_t q[$];
  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .cin(cin),
    .busy(busy), .done(done), .s(s), .c(c), .v(v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (done) begin
    if (q.size() == 0) chk("spurious_done", 1, 0);
    else begin
      vec_t e;
      e = q.pop_front();
      chk("sum", 32'(s), 32'(e.s));
      chk("carry", 32'(c), 32'(e.c));
      chk("ovf", 32'(v), 32'(e.v));
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit push);
    vec_t e;
    logic [W:0] full;
    start = 1;
    in1 = a;
    in2 = b;
    cin = ci;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.a = a; e.b = b; e.ci = ci;
    e.s = full[W-1:0];
    e.c = full[W];
    e.v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    if (push) q.push_back(e);
  endtask
  task automatic wait_done(output int n, input bit chk_busy);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 0;
      if (!done && chk_busy) chk("busy_during_add", 32'(busy), 1);
    end while (!done && n < 20);
    if (!done) chk("done_timeout", 0, 1);
    else chk("busy_at_done", 32'(busy), 0);
  endtask
  initial begin
    int n;
    logic [W-1:0] hs;
    logic hc, hv;
    tbl[0] = '{16'h1234, 16'h4321, 0, 16'h5555, 0, 0};
    tbl[1] = '{16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0};
    tbl[2] = '{16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1};
    tbl[3] = '{16'h8000, 16'h8000, 0, 16'h0000, 1, 1};
    tbl[4] = '{16'h4000, 16'h4000, 0, 16'h8000, 0, 1};
    tbl[5] = '{16'h8000, 16'h7FFF, 1, 16'h0000, 1, 0};
    tbl[6] = '{16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_scv", {15'd0, s, c, v}, 0);
    rst = 0;
    foreach (tbl[i]) begin
      vec_t e;
      @(negedge clk);
      issue(tbl[i].a, tbl[i].b, tbl[i].ci, 1);
      e = q[q.size()-1];
      chk("table_model_s", 32'(e.s), 32'(tbl[i].s));
      chk("table_model_cv", {e.c, e.v}, {tbl[i].c, tbl[i].v});
      wait_done(n, 1);
      chk("latency", n, N + 1);
    end
    hs = s; hc = c; hv = v;
    repeat (10) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 0);
      chk("hold_scv", {s, c, v}, {hs, hc, hv});
    end
    issue(16'h0001, 16'h0002, 0, 1);
    @(posedge clk);
    @(negedge clk) start = 0;
    @(posedge clk);
    @(negedge clk) issue(16'hAAAA, 16'h5555, 0, 0);
    @(posedge clk);
    @(negedge clk) start = 0;
    wait_done(n, 1);
    chk("ignored_start_s", 32'(s), 32'h0003);
    issue(16'h000F, 16'h0001, 0, 1);
    wait_done(n, 1);
    chk("b2b_latency", n, N + 1);
    chk("b2b_s", 32'(s), 32'h0010);
    @(negedge clk);
    issue(16'h1111, 16'h1111, 0, 0);
    @(posedge clk);
    @(negedge clk) start = 0;
    @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_scv", {15'd0, s, c, v}, 0);
    rst = 0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", {busy, done}, 0);
    end
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
